// File: rtl/bpsk_coherent_receiver.sv
// Coherent BPSK receiver: integrate-and-dump correlation against the local sine, bit slicing, codeword assembly.
// Optional macro BPSK_RX_ERASURE_EN adds a per-bit low-confidence (erasure) output word.
module bpsk_coherent_receiver #(
    parameter int unsigned SAMPLE_NUMBER = 256,
    parameter int unsigned SAMPLE_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH    = 12,
    parameter int unsigned ERASE_THRESH  = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [SAMPLE_WIDTH-1:0]          signal_in,
    input  logic [SAMPLE_WIDTH-1:0]          sine_in,
    input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
    output logic [DATA_WIDTH-1:0]            q,
    output logic                             q_valid,
    output logic [$clog2(DATA_WIDTH):0]      bit_cnt,
    output logic                             locked
`ifdef BPSK_RX_ERASURE_EN
    ,
    output logic [DATA_WIDTH-1:0]            erasure
`endif
);

    localparam int unsigned CW = $clog2(SAMPLE_NUMBER);
    localparam int unsigned SW = SAMPLE_WIDTH;
    localparam int unsigned XW = SW + 1;
    localparam int unsigned PW = 2 * SW + 2;
    localparam int unsigned AW = PW + CW;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [XW-1:0] MID = XW'(1) << (SW - 1);

    typedef enum logic [1:0] {SYNC, INTEG, DUMP} state_t;

    state_t                state_q, state_d;
    logic                  accept_c, lose_c, dump_c;
    logic signed [XW-1:0]  s_c, r_c;
    logic signed [PW-1:0]  s_ext_c, r_ext_c, prod_c;
    logic signed [PW-1:0]  prod_q;
    logic                  last_q, v_q;
    logic [CW-1:0]         exp_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  prod_ext_c;
    logic                  bit_c;
    logic [DW-1:0]         word_c;
    logic [DW-2:0]         q_shift;

    // Remove offset-binary midpoint, sign-extend, multiply
    assign s_c        = {1'b0, signal_in} - MID;
    assign r_c        = {1'b0, sine_in} - MID;
    assign s_ext_c    = {{(PW-XW){s_c[XW-1]}}, s_c};
    assign r_ext_c    = {{(PW-XW){r_c[XW-1]}}, r_c};
    assign prod_c     = s_ext_c * r_ext_c;
    assign prod_ext_c = {{CW{prod_q[PW-1]}}, prod_q};
    assign bit_c      = ~acc_q[AW-1];
    assign word_c     = {q_shift, bit_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SYNC;
        else     state_q <= state_d;
    end

    // Next state plus sample-accept / lock-loss / dump controls
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        lose_c   = 1'b0;
        dump_c   = 1'b0;
        case (state_q)
            SYNC: begin
                if (en && cnt_in == '0) begin
                    accept_c = 1'b1;
                    state_d  = INTEG;
                end
            end
            INTEG: begin
                if (en && cnt_in != exp_q) begin
                    lose_c  = 1'b1;
                    state_d = SYNC;
                end else begin
                    accept_c = en;
                    if (v_q && last_q) state_d = DUMP;
                end
            end
            DUMP: begin
                if (en && cnt_in != exp_q) begin
                    lose_c  = 1'b1;
                    state_d = SYNC;
                end else begin
                    accept_c = en;
                    dump_c   = 1'b1;
                    state_d  = INTEG;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Stage 1: product register, last-sample flag, expected next phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            last_q <= 1'b0;
            v_q    <= 1'b0;
            exp_q  <= '0;
        end else begin
            v_q <= accept_c;
            if (accept_c) begin
                prod_q <= prod_c;
                last_q <= (cnt_in == CW'(SAMPLE_NUMBER - 1));
                exp_q  <= cnt_in + CW'(1);
            end
        end
    end

    // Stage 2: accumulate; on dump restart from the incoming product so no sample is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (lose_c || state_q == SYNC) begin
            acc_q <= '0;
        end else if (dump_c) begin
            acc_q <= v_q ? prod_ext_c : '0;
        end else if (v_q) begin
            acc_q <= acc_q + prod_ext_c;
        end
    end

    // Codeword assembly and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
            bit_cnt <= '0;
            q_shift <= '0;
            locked  <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            locked  <= (state_d != SYNC);
            if (lose_c) begin
                bit_cnt <= '0;
            end else if (dump_c) begin
                q_shift <= word_c[DW-2:0];
                if (bit_cnt == BW'(DW - 1)) begin
                    q       <= word_c;
                    q_valid <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

`ifdef BPSK_RX_ERASURE_EN
    logic [AW-1:0] mag_c;
    logic          era_bit_c;
    logic [DW-1:0] era_word_c;
    logic [DW-2:0] era_shift;

    // A bit is erased when its mean correlation magnitude is below threshold
    assign mag_c      = acc_q[AW-1] ? AW'(-acc_q) : AW'(acc_q);
    assign era_bit_c  = (mag_c >> CW) < AW'(ERASE_THRESH);
    assign era_word_c = {era_shift, era_bit_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            erasure   <= '0;
            era_shift <= '0;
        end else if (!lose_c && dump_c) begin
            era_shift <= era_word_c[DW-2:0];
            if (bit_cnt == BW'(DW - 1)) erasure <= era_word_c;
        end
    end
`endif

endmodule
